// File: rtl/smac_pkg.sv
// Shared types and constants for the stochastic MAC sequencer.
// The state enum is also used by benches that observe the debug state port.
package smac_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      CLR  = 3'd2,
      RUN  = 3'd3,
      DONE = 3'd4
   } smac_state_t;

   localparam int SMAC_PIPE_LAT = 2;
   localparam int SMAC_LANES    = 16;

endpackage

// File: rtl/smac_bitcnt.sv
// Window-gated ones counter for the MAC output stream.
// It also forms the signed bipolar numerator 2*ones - n.
module smac_bitcnt
   import smac_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             win,
   input  logic             bit_in,
   input  logic [LEN_W:0]   n,
   output logic [LEN_W:0]   ones,
   output logic [LEN_W+1:0] sum
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ones <= '0;
      end else if (clr) begin
         ones <= '0;
      end else if (win && bit_in) begin
         ones <= ones + 1'b1;
      end
   end

   // Both operands are LEN_W+2 wide, so 2*ones cannot overflow at ones = 2**LEN_W.
   assign sum = {ones, 1'b0} - {1'b0, n};

endmodule

// File: rtl/smac_seq_ctrl.sv
// Job sequencer for one 16-lane bipolar stochastic MAC: load, clear, run, count.
// Handshakes: a transfer happens on a rising edge where valid and ready are both high.
module smac_seq_ctrl
   import smac_pkg::*;
#(
   parameter int LEN_W    = 16,
   parameter int PIPE_LAT = SMAC_PIPE_LAT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             abort,
   output logic             loadA,
   output logic             loadB,
   output logic             rng_clr,
   output logic             rng_en,
   input  logic             oC,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [LEN_W:0]   res_ones,
   output logic [LEN_W+1:0] res_sum,
   output logic             busy,
   output smac_state_t      dbg_state
);

   localparam logic [LEN_W+1:0] LAT = (LEN_W+2)'(PIPE_LAT);
   localparam logic [LEN_W+1:0] ONE = (LEN_W+2)'(1);

   smac_state_t      state;
   smac_state_t      state_nxt;
   logic [LEN_W:0]   n_q;
   logic [LEN_W:0]   n_cfg;
   logic [LEN_W+1:0] cyc_q;
   logic [LEN_W+1:0] n_ext;
   logic [LEN_W+1:0] last_k;
   logic             accept;
   logic             is_last;
   logic             win;

   // A zero length encodes the full 2**LEN_W stream.
   assign n_cfg   = (cfg_len == '0) ? {1'b1, {LEN_W{1'b0}}} : {1'b0, cfg_len};
   assign accept  = start_valid && (state == IDLE);
   assign n_ext   = {1'b0, n_q};
   assign last_k  = n_ext + LAT - ONE;
   assign is_last = (cyc_q == last_k);
   assign win     = (state == RUN) && (cyc_q >= LAT) && (cyc_q < n_ext + LAT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         n_q   <= '0;
         cyc_q <= '0;
      end else begin
         if (accept) begin
            n_q <= n_cfg;
         end
         if (state == CLR) begin
            cyc_q <= '0;
         end else if (state == RUN) begin
            cyc_q <= cyc_q + ONE;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      start_ready = 1'b0;
      loadA       = 1'b0;
      loadB       = 1'b0;
      rng_clr     = 1'b0;
      rng_en      = 1'b0;
      res_valid   = 1'b0;
      unique case (state)
         IDLE: begin
            start_ready = 1'b1;
            if (start_valid) begin
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            loadA     = 1'b1;
            loadB     = 1'b1;
            state_nxt = abort ? IDLE : CLR;
         end
         CLR: begin
            rng_clr   = 1'b1;
            state_nxt = abort ? IDLE : RUN;
         end
         RUN: begin
            // Abort must stop the RNGs in the same cycle it is raised.
            rng_en = !abort;
            if (abort) begin
               state_nxt = IDLE;
            end else if (is_last) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            res_valid = 1'b1;
            if (res_ready) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

   smac_bitcnt #(
      .LEN_W (LEN_W)
   ) u_bitcnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (rng_clr),
      .win    (win),
      .bit_in (oC),
      .n      (n_q),
      .ones   (res_ones),
      .sum    (res_sum)
   );

endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Bench for smac_seq_ctrl: scenario tasks with randomized oC streams against a stream model.
module tb_smac_seq_ctrl;
   import smac_pkg::*;

   localparam int LEN_W = 16;
   localparam int PL    = SMAC_PIPE_LAT;

   logic              clk;
   logic              rst_n;
   logic              start_valid;
   logic              start_ready;
   logic [LEN_W-1:0]  cfg_len;
   logic              abort;
   logic              loadA;
   logic              loadB;
   logic              rng_clr;
   logic              rng_en;
   logic              oC;
   logic              res_valid;
   logic              res_ready;
   logic [LEN_W:0]    res_ones;
   logic [LEN_W+1:0]  res_sum;
   logic              busy;
   smac_state_t       dbg_state;

   int n_cmp = 0;
   int n_bad = 0;

   // Results of the most recent run_job call.
   int               job_n;
   int               job_lat;
   int               job_run;
   int               job_loads;
   int               job_clrs;
   int               job_exp_ones;
   bit               job_to;
   logic [LEN_W:0]   job_ones;
   logic [LEN_W+1:0] job_sum;

   smac_seq_ctrl #(.LEN_W(LEN_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_valid (start_valid),
      .start_ready (start_ready),
      .cfg_len     (cfg_len),
      .abort       (abort),
      .loadA       (loadA),
      .loadB       (loadB),
      .rng_clr     (rng_clr),
      .rng_en      (rng_en),
      .oC          (oC),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_ones    (res_ones),
      .res_sum     (res_sum),
      .busy        (busy),
      .dbg_state   (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stream shapes: 0 all ones, 1 ones only in the unsampled lead-in, 2 alternating, 3 random.
   function automatic bit pattern(input int mode, input int k);
      case (mode)
         0:       return 1'b1;
         1:       return (k < PL);
         2:       return (k % 2 == 0);
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Drives one job from IDLE until res_valid, returning in DONE with the result held.
   task automatic run_job(input int unsigned len_cfg, input int mode);
      bit q[$];
      int cyc;
      job_n     = (len_cfg == 0) ? (1 << LEN_W) : int'(len_cfg);
      job_to    = 1'b0;
      job_loads = 0;
      job_clrs  = 0;
      @(negedge clk);
      cfg_len     = len_cfg[LEN_W-1:0];
      start_valid = 1'b1;
      @(posedge clk);
      cyc = 1;
      while (1) begin
         @(negedge clk);
         start_valid = 1'b0;
         cfg_len     = LEN_W'($urandom);
         if (res_valid) break;
         if (cyc > job_n + 20) begin
            job_to = 1'b1;
            break;
         end
         if (loadA && loadB) job_loads++;
         if (rng_clr) job_clrs++;
         if (rng_en) begin
            q.push_back(pattern(mode, q.size()));
            oC = q[q.size()-1];
         end else begin
            oC = 1'b0;
         end
         @(posedge clk);
         cyc++;
      end
      oC           = 1'b0;
      job_lat      = cyc;
      job_run      = q.size();
      job_exp_ones = 0;
      for (int k = PL; k < job_n + PL && k < q.size(); k++) job_exp_ones += int'(q[k]);
      job_ones = res_ones;
      job_sum  = res_sum;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if ({start_ready, busy, res_valid, loadA, loadB, rng_clr, rng_en} !== 7'b1000000) begin
         n_bad++;
         $display("FAIL reset_ctrl: got %b expected 1000000",
                  {start_ready, busy, res_valid, loadA, loadB, rng_clr, rng_en});
      end
      n_cmp++;
      if (res_ones !== '0 || res_sum !== '0 || dbg_state !== IDLE) begin
         n_bad++;
         $display("FAIL reset_result: ones %0d sum %0d state %0d expected 0 0 0",
                  res_ones, $signed(res_sum), dbg_state);
      end
   endtask

   // One complete job with every result field checked against the stream model.
   task automatic test_stream(input string name, input int unsigned len_cfg, input int mode);
      int exp_sum;
      run_job(len_cfg, mode);
      n_cmp++;
      if (job_to) begin
         n_bad++;
         $display("FAIL %s_timeout: res_valid absent after %0d cycles, expected at %0d",
                  name, job_lat, job_n + PL + 3);
         do_reset();
         return;
      end
      exp_sum = 2 * job_exp_ones - job_n;
      n_cmp++;
      if (job_lat !== job_n + PL + 3) begin
         n_bad++;
         $display("FAIL %s_latency: got %0d expected %0d", name, job_lat, job_n + PL + 3);
      end
      n_cmp++;
      if (job_run !== job_n + PL || job_loads !== 1 || job_clrs !== 1) begin
         n_bad++;
         $display("FAIL %s_phases: rng_en %0d load %0d clr %0d expected %0d 1 1",
                  name, job_run, job_loads, job_clrs, job_n + PL);
      end
      n_cmp++;
      if (int'(job_ones) !== job_exp_ones) begin
         n_bad++;
         $display("FAIL %s_ones: got %0d expected %0d", name, job_ones, job_exp_ones);
      end
      n_cmp++;
      if (int'($signed(job_sum)) !== exp_sum) begin
         n_bad++;
         $display("FAIL %s_sum: got %0d expected %0d", name, $signed(job_sum), exp_sum);
      end
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      n_cmp++;
      if (res_valid !== 1'b0 || start_ready !== 1'b1 || dbg_state !== IDLE) begin
         n_bad++;
         $display("FAIL %s_release: valid %b ready %b state %0d expected 0 1 0",
                  name, res_valid, start_ready, dbg_state);
      end
   endtask

   task automatic test_abort();
      int k;
      int seen;
      k = 0;
      @(negedge clk);
      cfg_len     = 16'd50;
      start_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         start_valid = 1'b0;
         if (rng_en) begin
            if (k == 10) break;
            k++;
            oC = 1'($urandom_range(0, 1));
         end
      end
      n_cmp++;
      if (k !== 10) begin
         n_bad++;
         $display("FAIL abort_reach: run index %0d expected 10", k);
      end
      abort = 1'b1;
      #1;
      n_cmp++;
      if (rng_en !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_rng_en: got %b expected 0", rng_en);
      end
      @(negedge clk);
      abort = 1'b0;
      n_cmp++;
      if (dbg_state !== IDLE || busy !== 1'b0 || start_ready !== 1'b1 || res_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_idle: state %0d busy %b ready %b valid %b expected 0 0 1 0",
                  dbg_state, busy, start_ready, res_valid);
      end
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (res_valid || rng_en) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_bad++;
         $display("FAIL abort_quiet: %0d active cycles expected 0", seen);
      end
      test_stream("after_abort", 17, 3);
   endtask

   task automatic test_backpressure();
      logic [LEN_W+1:0] held_sum;
      logic [LEN_W:0]   held_ones;
      int               bad_cycles;
      run_job(20, 3);
      n_cmp++;
      if (job_to || int'(job_ones) !== job_exp_ones) begin
         n_bad++;
         $display("FAIL hold_ones: got %0d expected %0d (timeout %b)", job_ones, job_exp_ones, job_to);
      end
      held_sum   = job_sum;
      held_ones  = job_ones;
      bad_cycles = 0;
      for (int i = 0; i < 5; i++) begin
         start_valid = 1'b1;
         cfg_len     = 16'd7;
         abort       = (i == 2);
         @(negedge clk);
         if (res_valid !== 1'b1 || res_sum !== held_sum || res_ones !== held_ones ||
             start_ready !== 1'b0 || dbg_state !== DONE) bad_cycles++;
      end
      n_cmp++;
      if (bad_cycles !== 0) begin
         n_bad++;
         $display("FAIL hold_stable: %0d unstable cycles expected 0", bad_cycles);
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      abort       = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      abort     = 1'b0;
      n_cmp++;
      if (dbg_state !== IDLE || res_valid !== 1'b0 || start_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL hold_release: state %0d valid %b ready %b expected 0 0 1",
                  dbg_state, res_valid, start_ready);
      end
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0) begin
         n_bad++;
         $display("FAIL hold_no_start: busy %b expected 0", busy);
      end
   endtask

   task automatic test_async_reset();
      int k;
      k = 0;
      @(negedge clk);
      cfg_len     = 16'd100;
      start_valid = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 200 && k < 30; i++) begin
         @(negedge clk);
         start_valid = 1'b0;
         oC = 1'b1;
         if (rng_en) k++;
      end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({start_ready, busy, res_valid, loadA, loadB, rng_clr, rng_en} !== 7'b1000000 ||
          res_ones !== '0 || res_sum !== '0) begin
         n_bad++;
         $display("FAIL async_reset: ctrl %b ones %0d sum %0d expected 1000000 0 0",
                  {start_ready, busy, res_valid, loadA, loadB, rng_clr, rng_en},
                  res_ones, $signed(res_sum));
      end
      oC = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (dbg_state !== IDLE || start_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL async_release: state %0d ready %b expected 0 1", dbg_state, start_ready);
      end
      test_stream("after_reset", 5, 3);
   endtask

   initial begin
      rst_n       = 1'b0;
      start_valid = 1'b0;
      cfg_len     = '0;
      abort       = 1'b0;
      oC          = 1'b0;
      res_ready   = 1'b0;
      test_reset();
      test_stream("ones256", 256, 0);
      test_stream("zeros256", 256, 1);
      test_stream("len1", 1, 3);
      for (int i = 0; i < 6; i++) begin
         test_stream("random", $urandom_range(1, 40), $urandom_range(0, 3));
      end
      test_abort();
      test_backpressure();
      test_async_reset();
      test_stream("full_len", 0, 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
